// File: rtl/branch_target_unit.sv
// Branch target unit: holds the fetch PC and resolves relative, J and JR
// transfers that take effect after a single branch delay slot.
module branch_target_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                IMM_W        = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [1:0]        br_mode,
    input  logic [IMM_W-1:0]  immdt,
    input  logic [25:0]       jindex,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic              in_delay_slot,
    output logic              fault
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [1:0] MODE_REL  = 2'b00;
    localparam logic [1:0] MODE_J    = 2'b01;
    localparam logic [1:0] MODE_JR   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    state_t            state, state_next;
    logic [ADDR_W-1:0] target, target_next, pc_next;
    logic [ADDR_W-1:0] pc_plus4, imm_ext, rel_target, j_target, sel_target;
    logic              fault_next, take, fault_set, jr_misaligned;

    // Candidate target addresses; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        pc_plus4       = pc + ADDR_W'(4);
        imm_ext        = {{(ADDR_W-IMM_W){immdt[IMM_W-1]}}, immdt};
        rel_target     = pc_plus4 + (imm_ext << 2);
        j_target       = pc_plus4;
        j_target[27:0] = {jindex, 2'b00};
    end

    // Decode whether a transfer is taken from IDLE and which errors it raises.
    always_comb begin
        jr_misaligned = (reg_target[1:0] != 2'b00);
        take          = 1'b0;
        sel_target    = rel_target;
        case (br_mode)
            MODE_REL: take = br_valid & br_taken;
            MODE_J: begin
                take       = br_valid;
                sel_target = j_target;
            end
            MODE_JR: begin
                take       = br_valid & ~jr_misaligned;
                sel_target = reg_target;
            end
            default: take = 1'b0;
        endcase
        // Errors: reserved mode, misaligned JR, or any would-be-taken
        // transfer sitting in a delay slot.
        fault_set = br_valid & ((br_mode == MODE_RSVD)
                              | ((br_mode == MODE_JR) & jr_misaligned)
                              | ((state == PENDING) & ((br_mode != MODE_REL) | br_taken)));
    end

    // Next-state logic: sequential flow in IDLE, redirect out of PENDING.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_next  = state;
        pc_next     = pc;
        target_next = target;
        fault_next  = fault;
        if (advance) begin
            fault_next = fault | fault_set;
            case (state)
                IDLE: begin
                    pc_next = pc_plus4;
                    if (take) begin
                        target_next = sel_target;
                        state_next  = PENDING;
                    end
                end
                PENDING: begin
                    pc_next    = target;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register with asynchronous reset of every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_VECTOR;
            // NOTE: the latched target is reset too, so a reset during a
            // pending transfer cannot leak the old target into the next run.
            target <= '0;
            fault  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state  <= state_next;
            pc     <= pc_next;
            target <= target_next;
            fault  <= fault_next;
        end
    end

    assign in_delay_slot = (state == PENDING);

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: directed corner cases plus
// randomized traffic compared against a behavioural PC model.
module tb_branch_target_unit;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        advance = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [1:0]  br_mode = 2'b00;
    logic [15:0] immdt = '0;
    logic [25:0] jindex = '0;
    logic [31:0] reg_target = '0;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc = RV;
    logic [31:0] m_target = '0;
    logic        m_pending = 1'b0;
    logic        m_fault = 1'b0;

    branch_target_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (advance),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_mode       (br_mode),
        .immdt         (immdt),
        .jindex        (jindex),
        .reg_target    (reg_target),
        .pc            (pc),
        .in_delay_slot (in_delay_slot),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, computed from the architectural rules.
    task automatic model_step(input logic adv, input logic v, input logic tk,
                              input logic [1:0] mode, input logic [15:0] imm,
                              input logic [25:0] ji, input logic [31:0] rt);
        int          off;
        logic [31:0] seq;
        if (!adv) return;
        if (m_pending) begin
            if (v && (mode != 2'd0 || tk)) m_fault = 1'b1;
            m_pc      = m_target;
            m_pending = 1'b0;
        end else begin
            seq = m_pc + 32'd4;
            if (v) begin
                case (mode)
                    2'd0: if (tk) begin
                        off       = $signed(imm);
                        m_target  = seq + 32'(off * 4);
                        m_pending = 1'b1;
                    end
                    2'd1: begin
                        m_target  = (seq & 32'hF000_0000) + {4'b0, ji, 2'b00};
                        m_pending = 1'b1;
                    end
                    2'd2: if (rt % 4 != 0) m_fault = 1'b1;
                          else begin
                              m_target  = rt;
                              m_pending = 1'b1;
                          end
                    default: m_fault = 1'b1;
                endcase
            end
            m_pc = seq;
        end
    endtask

    // Drive one cycle, update the model, sample #1 after the edge and compare.
    task automatic cyc(input logic adv, input logic v, input logic tk,
                       input logic [1:0] mode, input logic [15:0] imm,
                       input logic [25:0] ji, input logic [31:0] rt);
        advance = adv; br_valid = v; br_taken = tk; br_mode = mode;
        immdt = imm; jindex = ji; reg_target = rt;
        model_step(adv, v, tk, mode, imm, ji, rt);
        @(posedge clk);
        #1;
        check("model_pc", pc, m_pc);
        check("model_ds", {31'b0, in_delay_slot}, {31'b0, m_pending});
        check("model_fault", {31'b0, fault}, {31'b0, m_fault});
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
    endtask

    // Reset pulse between clock edges; reset values checked asynchronously.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_pc", pc, RV);
        check("rst_ds", {31'b0, in_delay_slot}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        rst_n = 1'b1;
        m_pc = RV; m_target = '0; m_pending = 1'b0; m_fault = 1'b0;
    endtask

    // Move pc to an aligned address with a JR and its delay slot.
    task automatic goto_pc(input logic [31:0] addr);
        cyc(1'b1, 1'b1, 1'b0, 2'b10, 16'h0, 26'h0, addr);
        idle_cyc();
        check("goto_pc", pc, addr);
    endtask

    task automatic rel_branch(input string tag, input logic [31:0] start,
                              input logic [15:0] imm, input logic [31:0] tgt);
        goto_pc(start);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, imm, 26'h0, 32'h0);
        check({tag, "_slot_pc"}, pc, start + 32'd4);
        check({tag, "_slot_ds"}, {31'b0, in_delay_slot}, 32'd1);
        idle_cyc();
        check({tag, "_tgt_pc"}, pc, tgt);
        check({tag, "_tgt_ds"}, {31'b0, in_delay_slot}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] slot_pc;
        #12;
        do_reset();

        // J from the reset vector.
        cyc(1'b1, 1'b1, 1'b0, 2'b01, 16'h0, 26'h10, 32'h0);
        check("j_slot_pc", pc, 32'hBFC00004);
        check("j_slot_ds", {31'b0, in_delay_slot}, 32'd1);
        idle_cyc();
        check("j_tgt_pc", pc, 32'hB0000040);

        // Relative branches: forward, backward and immediate extremes.
        rel_branch("fwd", 32'd16, 16'd8, 32'd52);
        rel_branch("bwd", 32'd36, 16'hFFF8, 32'd8);
        rel_branch("maxp", 32'd4, 16'h7FFF, 32'd131076);
        rel_branch("maxn", 32'd159996, 16'h8000, 32'd28928);

        // Not-taken conditional branch.
        goto_pc(32'h0000_1000);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 16'h0040, 26'h0, 32'h0);
        check("nt_pc", pc, 32'h0000_1004);
        check("nt_ds", {31'b0, in_delay_slot}, 32'd0);

        // Stall in PENDING with changing inputs, then redirect.
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 16'd4, 26'h0, 32'h0);
        slot_pc = pc;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'($urandom), 2'($urandom), 16'($urandom), 26'($urandom), $urandom);
            check("stall_pc", pc, slot_pc);
            check("stall_ds", {31'b0, in_delay_slot}, 32'd1);
        end
        check("stall_fault", {31'b0, fault}, 32'd0);
        idle_cyc();
        check("stall_tgt_pc", pc, 32'h0000_1018);

        // Misaligned JR: fault, sequential flow.
        slot_pc = pc;
        cyc(1'b1, 1'b1, 1'b0, 2'b10, 16'h0, 26'h0, 32'h00400002);
        check("jrmis_fault", {31'b0, fault}, 32'd1);
        check("jrmis_pc", pc, slot_pc + 32'd4);
        check("jrmis_ds", {31'b0, in_delay_slot}, 32'd0);

        // Taken branch inside a delay slot is ignored and faults.
        do_reset();
        goto_pc(32'h0000_2000);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 16'd16, 26'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 16'd100, 26'h0, 32'h0);
        check("dsbr_pc", pc, 32'h0000_2044);
        check("dsbr_fault", {31'b0, fault}, 32'd1);
        check("dsbr_ds", {31'b0, in_delay_slot}, 32'd0);
        idle_cyc();
        check("dsbr_seq_pc", pc, 32'h0000_2048);

        // Reserved mode faults and is not taken.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 16'd8, 26'h5, 32'h8);
        check("rsvd_fault", {31'b0, fault}, 32'd1);
        check("rsvd_pc", pc, RV + 32'd4);
        check("rsvd_ds", {31'b0, in_delay_slot}, 32'd0);

        // Asynchronous reset asserted mid-cycle while PENDING.
        do_reset();
        goto_pc(32'h0000_3000);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 16'd64, 26'h0, 32'h0);
        check("arst_pre_ds", {31'b0, in_delay_slot}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, RV);
        check("arst_ds", {31'b0, in_delay_slot}, 32'd0);
        check("arst_fault", {31'b0, fault}, 32'd0);
        #1;
        rst_n = 1'b1;
        m_pc = RV; m_target = '0; m_pending = 1'b0; m_fault = 1'b0;
        idle_cyc();
        check("arst_after_pc", pc, RV + 32'd4);
        check("arst_after_ds", {31'b0, in_delay_slot}, 32'd0);

        // Randomized traffic against the model, with periodic resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt;
            if (i % 50 == 0) do_reset();
            rt = $urandom;
            if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
            cyc(1'($urandom_range(4) != 0), 1'($urandom), 1'($urandom),
                2'($urandom), 16'($urandom), 26'($urandom), rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/address width (>= 28).
REQ-002 SHALL have parameter IMM_W, default 16, meaning branch immediate width in instructions (< ADDR_W - 2).
REQ-003 SHALL have parameter RESET_VECTOR, default 32'hBFC00000 truncated to ADDR_W, meaning PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port advance, input, 1 bit: PC update enable; low means stall.
REQ-007 SHALL have port br_valid, input, 1 bit: the instruction at pc is a control-transfer instruction.
REQ-008 SHALL have port br_taken, input, 1 bit: the branch condition holds; ignored for J/JR.
REQ-009 SHALL have port br_mode, input, 2 bits: 00 relative, 01 J absolute, 10 JR register, 11 reserved.
REQ-010 SHALL have port immdt, input, IMM_W bits: signed relative offset in words.
REQ-011 SHALL have port jindex, input, 26 bits: J-type instruction index.
REQ-012 SHALL have port reg_target, input, ADDR_W bits: JR target address.
REQ-013 SHALL have port pc, output, ADDR_W bits: address of the current instruction (registered).
REQ-014 SHALL have port in_delay_slot, output, 1 bit: pc is a branch delay slot (registered).
REQ-015 SHALL have port fault, output, 1 bit: sticky error flag (registered).

Function
REQ-016 SHALL have two states: IDLE (sequential flow) and PENDING (taken transfer latched; pc is in the delay slot); in_delay_slot = (state == PENDING).
REQ-017 SHALL ignore every input other than rst_n while advance = 0: pc, state, latched target and fault all held.
REQ-018 SHALL, on an advance edge in IDLE without a taken transfer, set pc <= pc + 4 and remain in IDLE.
REQ-019 SHALL treat a transfer as taken when br_valid = 1 and either br_mode = 00 with br_taken = 1, or br_mode is 01 or 10.
REQ-020 SHALL, on an advance edge in IDLE with a taken transfer, set pc <= pc + 4, latch the target, and enter PENDING.
REQ-021 SHALL compute the relative target as (pc + 4) + (sign_extend(immdt) << 2).
REQ-022 SHALL compute the J target as {(pc + 4)[ADDR_W-1:28], jindex, 2'b00}.
REQ-023 SHALL take reg_target unchanged as the JR target.
REQ-024 SHALL perform all address arithmetic modulo 2^ADDR_W; wrap-around is silent and is not a fault.
REQ-025 SHALL, on an advance edge in PENDING, set pc <= latched target and return to IDLE.
REQ-026 SHALL ignore br_valid in PENDING (branch in a delay slot); if it would have been taken, fault SHALL be set.
REQ-027 SHALL, for a JR whose reg_target[1:0] != 0, set fault, take no transfer, and follow REQ-018.
REQ-028 SHALL treat br_mode = 11 with br_valid = 1 as not taken and SHALL set fault.
REQ-029 SHALL keep fault set until reset.
REQ-030 SHALL hold the latched target stable across any stall while in PENDING.

Reset
REQ-031 SHALL, while rst_n = 0, immediately force pc = RESET_VECTOR, state = IDLE, in_delay_slot = 0, fault = 0, latched target = 0, independent of clk.
REQ-032 SHALL, on reset asserted during PENDING, discard the latched target; the first advance after release yields pc = RESET_VECTOR + 4.

Verification
REQ-033 SHALL cover forward branch: pc=16, br_mode=00, taken, immdt=8, advance -> pc=20 with in_delay_slot=1; next advance -> pc=52, in_delay_slot=0.
REQ-034 SHALL cover backward branch and extremes: pc=36, immdt=16'hFFF8 -> target 8; pc=4, immdt=16'h7FFF -> target 131076; pc=159996, immdt=16'h8000 -> target 28928.
REQ-035 SHALL cover J and JR: pc=32'hBFC00000, J with jindex=26'h10 -> delay slot 32'hBFC00004, then 32'hB0000040; JR reg_target=32'h00400002 -> fault=1 and pc advances by 4.
REQ-036 SHALL cover stall: in PENDING, advance=0 for 3 cycles with changing inputs -> pc, target and in_delay_slot unchanged; the next advance redirects correctly.
REQ-037 SHALL cover a taken branch presented in the delay slot, showing it is ignored with fault=1, and a not-taken branch (br_taken=0), showing pc + 4 with in_delay_slot staying 0.
REQ-038 SHALL cover asynchronous reset asserted mid-cycle in PENDING, showing pc=RESET_VECTOR before the next clk edge and no redirect after release.
